// File: rtl/decoder_func_pkg.sv
// Shared constants, minterm decoder and configuration record for the
// programmable decoder function generator.
package decoder_func_pkg;

    localparam int DEF_SEL_W    = 3;
    localparam int DEF_NUM_FUNC = 3;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_NM       = 1 << DEF_SEL_W;

    // Widest select the shared decoder supports; callers cast down to NM.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_NM    = 1 << MAX_SEL_W;

    // One function's programmable state at the default geometry.
    typedef struct packed {
        logic [DEF_NM-1:0] mask;
        logic              inv;
    } cfg_t;

    // One-hot minterm vector for a select value.
    function automatic logic [MAX_NM-1:0] onehot_dec(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_NM-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/decoder_func_slice.sv
// One output function: programmable minterm mask with inversion, plus a
// saturating hit counter fed by the top-level output transfer.
module decoder_func_slice
    import decoder_func_pkg::*;
#(
    parameter int            NM       = DEF_NM,
    parameter int            CNT_W    = DEF_CNT_W,
    parameter logic [NM-1:0] RST_MASK = '0,
    parameter logic          RST_INV  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [NM-1:0]    cfg_mask,
    input  logic             cfg_inv,
    input  logic [NM-1:0]    dec,
    input  logic             cnt_clr,
    input  logic             hit,
    output logic             func,
    output logic [CNT_W-1:0] cnt
);

    typedef struct packed {
        logic [NM-1:0] mask;
        logic          inv;
    } slice_cfg_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    slice_cfg_t       cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Configuration write: new mask/inv take effect after the edge.
    always_comb begin
        cfg_d = cfg_q;
        if (cfg_we) begin
            cfg_d.mask = cfg_mask;
            cfg_d.inv  = cfg_inv;
        end else begin
            cfg_d = cfg_q;
        end
    end

    // Function term from the currently stored configuration.
    always_comb begin
        func = (|(dec & cfg_q.mask)) ^ cfg_q.inv;
    end

    // Hit counter: clear has priority, otherwise count up and stick at max.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Slice state registers with reset to the programmed defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q.mask <= RST_MASK;
            cfg_q.inv  <= RST_INV;
            cnt_q      <= '0;
        end else begin
            cfg_q <= cfg_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/decoder_func_gen.sv
// Programmable decoder function generator: decodes a select into minterms,
// evaluates NUM_FUNC masked OR/NOR functions and registers the result
// behind a single valid/ready stage.
module decoder_func_gen
    import decoder_func_pkg::*;
#(
    parameter int SEL_W    = DEF_SEL_W,
    parameter int NUM_FUNC = DEF_NUM_FUNC,
    parameter int CNT_W    = DEF_CNT_W,
    parameter logic [NUM_FUNC*(2**SEL_W)-1:0] RST_MASKS = 24'h620994,
    parameter logic [NUM_FUNC-1:0]            RST_INV   = 3'b100
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SEL_W-1:0]             in_sel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [(2**SEL_W)-1:0]        dec_out,
    output logic [NUM_FUNC-1:0]          func_out,
    input  logic                         cfg_we,
    input  logic [((NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1)-1:0] cfg_idx,
    input  logic [(2**SEL_W)-1:0]        cfg_mask,
    input  logic                         cfg_inv,
    input  logic                         cnt_clr,
    output logic [NUM_FUNC*CNT_W-1:0]    hit_cnt
);

    localparam int NM    = 2 ** SEL_W;
    localparam int IDX_W = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1;

    logic [NM-1:0]       dec_s;
    logic [NUM_FUNC-1:0] func_s;
    logic [NUM_FUNC-1:0] cfg_we_s;
    logic                accept_s;
    logic                xfer_s;

    logic                out_valid_q, out_valid_d;
    logic [NM-1:0]       dec_q, dec_d;
    logic [NUM_FUNC-1:0] func_q, func_d;

    // Minterm decode of the incoming select.
    always_comb begin
        dec_s = NM'(onehot_dec(MAX_SEL_W'(in_sel)));
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;
    assign xfer_s   = out_valid_q && out_ready;

    for (genvar k = 0; k < NUM_FUNC; k++) begin : g_func
        // Out-of-range indices match no slice, so those writes vanish.
        assign cfg_we_s[k] = cfg_we && (cfg_idx == IDX_W'(k));

        decoder_func_slice #(
            .NM       (NM),
            .CNT_W    (CNT_W),
            .RST_MASK (RST_MASKS[k*NM +: NM]),
            .RST_INV  (RST_INV[k])
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .cfg_we   (cfg_we_s[k]),
            .cfg_mask (cfg_mask),
            .cfg_inv  (cfg_inv),
            .dec      (dec_s),
            .cnt_clr  (cnt_clr),
            .hit      (xfer_s && func_q[k]),
            .func     (func_s[k]),
            .cnt      (hit_cnt[k*CNT_W +: CNT_W])
        );
    end

    // Output stage: load on accept, drop valid once drained, hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        dec_d       = dec_q;
        func_d      = func_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            dec_d       = dec_s;
            func_d      = func_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            func_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dec_q       <= dec_d;
            func_q      <= func_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dec_out   = dec_q;
    assign func_out  = func_q;

endmodule
